hazard_ctrl_unit: RTL and testbench
===================================

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 3, register-address width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, load-use bubble cycles (legal 1..7).
REQ-003 SHALL have parameter MC_LAT, default 4, multi-cycle-op result latency in cycles (legal 2..7).
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port rs1_D  in  REG_AW  Decode source register 1.
REQ-007 SHALL have port rs2_D  in  REG_AW  Decode source register 2.
REQ-008 SHALL have port jump_D  in  1  jump in Decode.
REQ-009 SHALL have port rd_E  in  REG_AW  Execute destination.
REQ-010 SHALL have port reg_write_E  in  1  Execute writes rd_E.
REQ-011 SHALL have port mem_read_E  in  1  Execute is a load.
REQ-012 SHALL have port mc_start_E  in  1  Execute launches a multi-cycle op (MUL/DIV) writing rd_E.
REQ-013 SHALL have port branch_taken_E  in  1  branch resolved taken in Execute.
REQ-014 SHALL have port rd_M  in  REG_AW  Memory-stage destination.
REQ-015 SHALL have port reg_write_M  in  1  Memory stage writes rd_M.
REQ-016 SHALL have port rd_W  in  REG_AW  Writeback destination.
REQ-017 SHALL have port reg_write_W  in  1  Writeback writes rd_W.
REQ-018 SHALL have port stall_F  out  1  hold PC.
REQ-019 SHALL have port stall_D  out  1  hold F/D register.
REQ-020 SHALL have port flush_F  out  1  clear F/D register.
REQ-021 SHALL have port flush_D  out  1  clear D/E register (bubble into Execute).
REQ-022 SHALL have port flush_E  out  1  clear E/M register.
REQ-023 SHALL have port forward_A  out  2  rs1 operand select: 00 regfile, 01 E, 10 M, 11 W.
REQ-024 SHALL have port forward_B  out  2  rs2 operand select, same encoding.
REQ-025 SHALL have port mc_busy  out  1  multi-cycle op outstanding.

Function
REQ-026 SHALL treat register 0 as never hazarding and never forwarded.
REQ-027 SHALL select forwarding per operand with priority E > M > W, source X eligible when reg_write_X, rd_X != 0, rd_X == rs; E ineligible when mem_read_E or mc_start_E.
REQ-028 SHALL detect load-use when mem_read_E, rd_E != 0, rd_E equals rs1_D or rs2_D, and no stall counter active.
REQ-029 SHALL on load-use assert stall_F, stall_D, flush_D in the detect cycle and load a 3-bit counter with LOAD_LAT-1, holding the same three outputs while counter nonzero, decrementing once per cycle.
REQ-030 SHALL on mc_start_E with rd_E != 0 set mc_busy next cycle, record rd_E as pending, and load a down-counter with MC_LAT-1.
REQ-031 SHALL clear mc_busy and pending register on the edge where the counter leaves 1; mc_busy lasts exactly MC_LAT-1 cycles.
REQ-032 SHALL assert stall_F, stall_D, flush_D while mc_busy and pending register equals nonzero rs1_D or rs2_D.
REQ-033 SHALL ignore mc_start_E while mc_busy (upstream guarantees one outstanding op); behaviour undefined beyond no lock-up.
REQ-034 SHALL on branch_taken_E assert flush_F, flush_D, clear the load-use counter, force stall_F/stall_D to 0 that cycle; mc state unaffected.
REQ-035 SHALL on jump_D assert flush_F only when no stall is asserted that cycle; stall wins, jump re-evaluated after stall.
REQ-036 SHALL keep flush_E 0 except on branch_taken_E with mc_start_E (cancel launch, no pending set).
REQ-037 SHALL produce stall/flush/forward outputs combinationally from inputs and current state; no output registered.

Reset
REQ-038 SHALL, while rst high at a rising edge, clear both counters, pending register and mc_busy; all stall/flush outputs 0 and forward selects 00 during the rst cycle.

Verification
REQ-039 SHALL verify LOAD_LAT=3: mem_read_E, rd_E=3, rs1_D=3 -> stall_F/stall_D/flush_D high 3 consecutive cycles, then low.
REQ-040 SHALL verify forwarding: rd_E=rd_M=rd_W=5 all writing, rs2_D=5 -> forward_B=01; drop reg_write_E -> 10; rs2_D=0 -> 00.
REQ-041 SHALL verify MC_LAT=4: mc_start_E rd_E=2, next D reads r2 -> stall 3 cycles, mc_busy high 3 cycles, then forward_A from M/W as applicable.
REQ-042 SHALL verify branch_taken_E during second cycle of LOAD_LAT=3 stall -> stall drops immediately, flush_F/flush_D high, no further stall.
REQ-043 SHALL verify rst asserted mid mc_busy -> mc_busy 0 after edge, rs matching old pending produces no stall.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - pipeline hazard controller: forwarding, load-use and multi-cycle stalls, branch/jump flushes
module hazard_ctrl_unit #(
  parameter int REG_AW   = 3,
  parameter int LOAD_LAT = 1,
  parameter int MC_LAT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_D,
  input  logic [REG_AW-1:0] rs2_D,
  input  logic              jump_D,
  input  logic [REG_AW-1:0] rd_E,
  input  logic              reg_write_E,
  input  logic              mem_read_E,
  input  logic              mc_start_E,
  input  logic              branch_taken_E,
  input  logic [REG_AW-1:0] rd_M,
  input  logic              reg_write_M,
  input  logic [REG_AW-1:0] rd_W,
  input  logic              reg_write_W,
  output logic              stall_F,
  output logic              stall_D,
  output logic              flush_F,
  output logic              flush_D,
  output logic              flush_E,
  output logic [1:0]        forward_A,
  output logic [1:0]        forward_B,
  output logic              mc_busy
);

  localparam logic [2:0]        LU_RELOAD = 3'(LOAD_LAT - 1);
  localparam logic [2:0]        MC_RELOAD = 3'(MC_LAT - 1);
  localparam logic [REG_AW-1:0] R0        = '0;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_E  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b11;

  logic [2:0]        lu_cnt_q, lu_cnt_d;
  logic [2:0]        mc_cnt_q, mc_cnt_d;
  logic              mc_busy_q, mc_busy_d;
  logic [REG_AW-1:0] pend_q, pend_d;

  logic lu_hit, lu_stall, mc_hit, stall, mc_launch;
  logic e_fwd_ok, m_fwd_ok, w_fwd_ok;

  // Loads and multi-cycle ops have no result in Execute, so E never forwards for them.
  assign e_fwd_ok = reg_write_E && (rd_E != R0) && !mem_read_E && !mc_start_E;
  assign m_fwd_ok = reg_write_M && (rd_M != R0);
  assign w_fwd_ok = reg_write_W && (rd_W != R0);

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    logic [1:0] sel;
    sel = FWD_RF;
    if (rs != R0) begin
      if (e_fwd_ok && (rd_E == rs))      sel = FWD_E;
      else if (m_fwd_ok && (rd_M == rs)) sel = FWD_M;
      else if (w_fwd_ok && (rd_W == rs)) sel = FWD_W;
    end
    return sel;
  endfunction

  assign lu_hit = mem_read_E && (rd_E != R0) &&
                  ((rd_E == rs1_D) || (rd_E == rs2_D)) && (lu_cnt_q == 3'd0);
  assign lu_stall = lu_hit || (lu_cnt_q != 3'd0);

  assign mc_hit = mc_busy_q && (pend_q != R0) &&
                  ((pend_q == rs1_D) || (pend_q == rs2_D));

  // A taken branch squashes whatever is in Decode, so stalling it is pointless.
  assign stall = (lu_stall || mc_hit) && !branch_taken_E;

  assign mc_launch = mc_start_E && (rd_E != R0) && !mc_busy_q && !branch_taken_E;

  always_comb begin
    lu_cnt_d = lu_cnt_q;
    if (branch_taken_E) begin
      lu_cnt_d = 3'd0;
    end else if (lu_hit) begin
      lu_cnt_d = LU_RELOAD;
    end else if (lu_cnt_q != 3'd0) begin
      lu_cnt_d = lu_cnt_q - 3'd1;
    end
  end

  always_comb begin
    mc_cnt_d  = mc_cnt_q;
    mc_busy_d = mc_busy_q;
    pend_d    = pend_q;
    if (mc_busy_q) begin
      // A zero count while busy is unreachable; treating it like 1 guarantees release.
      if (mc_cnt_q <= 3'd1) begin
        mc_cnt_d  = 3'd0;
        mc_busy_d = 1'b0;
        pend_d    = R0;
      end else begin
        mc_cnt_d = mc_cnt_q - 3'd1;
      end
    end else if (mc_launch) begin
      mc_cnt_d  = MC_RELOAD;
      mc_busy_d = 1'b1;
      pend_d    = rd_E;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q  <= 3'd0;
      mc_cnt_q  <= 3'd0;
      mc_busy_q <= 1'b0;
      pend_q    <= R0;
    end else begin
      lu_cnt_q  <= lu_cnt_d;
      mc_cnt_q  <= mc_cnt_d;
      mc_busy_q <= mc_busy_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    stall_F   = 1'b0;
    stall_D   = 1'b0;
    flush_F   = 1'b0;
    flush_D   = 1'b0;
    flush_E   = 1'b0;
    forward_A = FWD_RF;
    forward_B = FWD_RF;
    if (!rst) begin
      stall_F   = stall;
      stall_D   = stall;
      flush_D   = stall || branch_taken_E;
      flush_F   = branch_taken_E || (jump_D && !stall);
      flush_E   = branch_taken_E && mc_start_E;
      forward_A = fwd_sel(rs1_D);
      forward_B = fwd_sel(rs2_D);
    end
  end

  assign mc_busy = mc_busy_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - scoreboard bench for hazard_ctrl_unit with LOAD_LAT=3, MC_LAT=4
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rs1_D, rs2_D, rd_E, rd_M, rd_W;
  logic       jump_D, reg_write_E, mem_read_E, mc_start_E, branch_taken_E;
  logic       reg_write_M, reg_write_W;
  logic       stall_F, stall_D, flush_F, flush_D, flush_E, mc_busy;
  logic [1:0] forward_A, forward_B;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(3), .LOAD_LAT(3), .MC_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .jump_D(jump_D),
    .rd_E(rd_E), .reg_write_E(reg_write_E), .mem_read_E(mem_read_E),
    .mc_start_E(mc_start_E), .branch_taken_E(branch_taken_E),
    .rd_M(rd_M), .reg_write_M(reg_write_M),
    .rd_W(rd_W), .reg_write_W(reg_write_W),
    .stall_F(stall_F), .stall_D(stall_D), .flush_F(flush_F), .flush_D(flush_D),
    .flush_E(flush_E), .forward_A(forward_A), .forward_B(forward_B), .mc_busy(mc_busy)
  );

  typedef struct {
    string      nm;
    logic [9:0] e;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // {stall_F, stall_D, flush_F, flush_D, flush_E, forward_A, forward_B, mc_busy}
  function automatic logic [9:0] ex(bit sf, bit sd, bit ff, bit fd, bit fe,
                                    bit [1:0] fa, bit [1:0] fb, bit mb);
    return {sf, sd, ff, fd, fe, fa, fb, mb};
  endfunction

  localparam logic [9:0] STALL = 10'b11_0_1_0_00_00_0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t       t;
      logic [9:0] act;
      t   = q.pop_front();
      act = {stall_F, stall_D, flush_F, flush_D, flush_E, forward_A, forward_B, mc_busy};
      n_checks++;
      if (act !== t.e) begin
        n_fail++;
        $display("FAIL %s: got sF=%b sD=%b fF=%b fD=%b fE=%b fA=%b fB=%b busy=%b, want sF=%b sD=%b fF=%b fD=%b fE=%b fA=%b fB=%b busy=%b",
                 t.nm, act[9], act[8], act[7], act[6], act[5], act[4:3], act[2:1], act[0],
                 t.e[9], t.e[8], t.e[7], t.e[6], t.e[5], t.e[4:3], t.e[2:1], t.e[0]);
      end
    end
  end

  task automatic idle();
    rs1_D = 0; rs2_D = 0; jump_D = 0;
    rd_E = 0; reg_write_E = 0; mem_read_E = 0; mc_start_E = 0; branch_taken_E = 0;
    rd_M = 0; reg_write_M = 0; rd_W = 0; reg_write_W = 0;
  endtask

  task automatic chk(string nm, logic [9:0] e);
    exp_t t;
    t.nm = nm;
    t.e  = e;
    q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    // Reset cycle with hazards present on the inputs
    mem_read_E = 1; reg_write_E = 1; rd_E = 3; rs1_D = 3; jump_D = 1;
    rd_M = 2; reg_write_M = 1; rs2_D = 2;
    chk("reset_outputs", ex(0,0,0,0,0,2'b00,2'b00,0));
    rst = 1'b0;
    idle();
    chk("idle", ex(0,0,0,0,0,2'b00,2'b00,0));

    // Forwarding priority
    rd_E = 5; rd_M = 5; rd_W = 5; reg_write_E = 1; reg_write_M = 1; reg_write_W = 1; rs2_D = 5;
    chk("fwd_b_from_E", ex(0,0,0,0,0,2'b00,2'b01,0));
    reg_write_E = 0;
    chk("fwd_b_from_M", ex(0,0,0,0,0,2'b00,2'b10,0));
    reg_write_M = 0; rs1_D = 5;
    chk("fwd_ab_from_W", ex(0,0,0,0,0,2'b11,2'b11,0));
    rs2_D = 0; rs1_D = 0; rd_E = 0; rd_M = 0; rd_W = 0; reg_write_E = 1; reg_write_M = 1;
    chk("fwd_r0_never", ex(0,0,0,0,0,2'b00,2'b00,0));
    idle();

    // Load-use, LOAD_LAT=3, rs1 match; jump suppressed during stall
    mem_read_E = 1; reg_write_E = 1; rd_E = 3; rs1_D = 3; rd_M = 3; reg_write_M = 1;
    chk("lu_detect", ex(1,1,0,1,0,2'b10,2'b00,0));
    idle(); rs1_D = 3; jump_D = 1;
    chk("lu_hold1_jump_masked", STALL);
    chk("lu_hold2", STALL);
    chk("lu_release_jump", ex(0,0,1,0,0,2'b00,2'b00,0));
    idle();

    // Load-use via rs2
    mem_read_E = 1; reg_write_E = 1; rd_E = 4; rs2_D = 4; rs1_D = 1;
    chk("lu_rs2_detect", STALL);
    idle(); rs2_D = 4;
    chk("lu_rs2_hold1", STALL);
    chk("lu_rs2_hold2", STALL);
    chk("lu_rs2_release", ex(0,0,0,0,0,2'b00,2'b00,0));
    idle();

    // Multi-cycle op, MC_LAT=4
    mc_start_E = 1; reg_write_E = 1; rd_E = 2; rs1_D = 2;
    chk("mc_launch", ex(0,0,0,0,0,2'b00,2'b00,0));
    idle(); rs1_D = 2;
    chk("mc_stall1", ex(1,1,0,1,0,2'b00,2'b00,1));
    chk("mc_stall2", ex(1,1,0,1,0,2'b00,2'b00,1));
    chk("mc_stall3", ex(1,1,0,1,0,2'b00,2'b00,1));
    rd_M = 2; reg_write_M = 1;
    chk("mc_done_fwd_M", ex(0,0,0,0,0,2'b10,2'b00,0));
    idle(); rs1_D = 2; rd_W = 2; reg_write_W = 1;
    chk("mc_done_fwd_W", ex(0,0,0,0,0,2'b11,2'b00,0));
    idle();

    // Branch cancels a multi-cycle launch
    branch_taken_E = 1; mc_start_E = 1; reg_write_E = 1; rd_E = 4; rs1_D = 4;
    chk("br_cancel_mc", ex(0,0,1,1,1,2'b00,2'b00,0));
    idle(); rs1_D = 4;
    chk("br_cancel_no_pending", ex(0,0,0,0,0,2'b00,2'b00,0));
    idle();

    // Branch in second cycle of a load-use stall
    mem_read_E = 1; reg_write_E = 1; rd_E = 3; rs1_D = 3;
    chk("lu_br_detect", STALL);
    idle(); rs1_D = 3; branch_taken_E = 1;
    chk("lu_br_flush", ex(0,0,1,1,0,2'b00,2'b00,0));
    idle(); rs1_D = 3;
    chk("lu_br_no_restall", ex(0,0,0,0,0,2'b00,2'b00,0));
    idle();

    // Reset in the middle of mc_busy
    mc_start_E = 1; reg_write_E = 1; rd_E = 2;
    chk("rst_mc_launch", ex(0,0,0,0,0,2'b00,2'b00,0));
    idle(); rs2_D = 2;
    chk("rst_mc_stall", ex(1,1,0,1,0,2'b00,2'b00,1));
    rst = 1'b1;
    chk("rst_mc_during_rst", ex(0,0,0,0,0,2'b00,2'b00,1));
    rst = 1'b0;
    chk("rst_mc_cleared", ex(0,0,0,0,0,2'b00,2'b00,0));
    idle();

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, %0d entries pending", q.size());
    $fatal(1, "watchdog");
  end

endmodule
